alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Sequential front end that feeds the 4-bit two's-complement display decoder.
- Takes operand A and operand B from four switches using a single raw push-button, then applies one of four ALU operations.
- Holds the 4-bit signed result on disp_w..disp_z, with disp_w as the MSB.
- Includes button synchronisation, debounce and rising-edge detection, so the board button can drive it directly.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required before a button level change is accepted (minimum 1).
- CNT_W, 16, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  4  operand value in two's complement; sw[3] is the sign bit.
- op  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- btn_enter  input  1  raw, asynchronous, bouncing push-button; active-high.
- disp_w  output  1  displayed value bit 3 (MSB/sign); goes to the decoder input w.
- disp_x  output  1  displayed value bit 2; goes to decoder input x.
- disp_y  output  1  displayed value bit 1; goes to decoder input y.
- disp_z  output  1  displayed value bit 0; goes to decoder input z.
- ovf  output  1  signed overflow of the last ADD/SUB; valid in SHOW only.
- led_a  output  1  high in LOAD_A.
- led_b  output  1  high in LOAD_B.
- led_res  output  1  high in SHOW.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = LOAD_A; reg_a, reg_b, reg_res = 0; ovf = 0.
  - Synchroniser flops = 0; debounced level = 0; debounce counter = 0.
  - disp_w..z = 0000; led_a = 1; led_b = 0; led_res = 0.
  - Reset applied mid-operation discards captured operands; no press pulse is generated on reset release.
- Button conditioning:
  - Two-flop synchroniser on btn_enter produces btn_sync.
  - Debounce counter increments each cycle that btn_sync differs from the debounced level, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes btn_sync and the counter clears.
  - press is a one-cycle strobe, registered in the cycle after the debounced level goes 0->1. Release produces no strobe.
  - A raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles is ignored.
  - Holding the button produces exactly one press.
- FSM (transitions happen only on press):
  - LOAD_A: display shows sw live (registered, 1-cycle latency). On press, reg_a <= sw and go to LOAD_B.
  - LOAD_B: display shows sw live. On press, reg_b <= sw, op is sampled, the result is computed from reg_a and sw, reg_res and ovf are registered, and the FSM goes to SHOW. The result appears on disp in the first SHOW cycle.
  - SHOW: display shows reg_res. sw and op changes are ignored. On press, ovf <= 0 and go to LOAD_A.
- Arithmetic (all 4-bit, wrap modulo 16):
  - ADD: a+b. ovf = (a[3]==b[3]) && (r[3]!=a[3]).
  - SUB: a-b, computed as a + ~b + 1. ovf = (a[3]!=b[3]) && (r[3]!=a[3]).
  - AND / OR: bitwise; ovf = 0.
  - No carry output; the carry out of bit 3 is discarded.
- Outputs: disp_* and led_* are registered; no combinational path from inputs to outputs.
- Simultaneous events: a press in the same cycle as an sw change uses the sw value sampled at that clock edge.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_ADD, OP_SUB, OP_AND, OP_OR.
  - state encodings ST_LOAD_A=2'd0, ST_LOAD_B=2'd1, ST_SHOW=2'd2. Value 2'd3 is illegal and recovers to LOAD_A.
  - DATA_W=4.
- Sub-module btn_conditioner: synchroniser, debounce counter and edge detect. Parameters DEBOUNCE_CYCLES and CNT_W; ports clk, rst_n, btn_raw, press.
- The ALU operation is a combinational function inside the top-level module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then clean presses with sw=0011, then sw=0100, op=00 -> SHOW, disp=0111, ovf=0, led_res=1.
- A=0111, B=0001, op=00 -> disp=1000 (-8), ovf=1. Next press -> LOAD_A, ovf=0.
- A=1000, B=0001, op=01 -> disp=0111, ovf=1. A=1110, B=1111, op=01 -> disp=1111, ovf=0.
- A=1100, B=1010: op=10 -> disp=1000, ovf=0; repeat with op=11 -> disp=1110.
- btn_enter high for 2 cycles, plus a burst of 1-cycle bounces -> no state change. Holding high for 20 cycles -> exactly one press.
- Capture A, then assert rst_n=0 asynchronously mid-LOAD_B -> immediate LOAD_A, disp=0000, ovf=0. After release, the first press captures a fresh A.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types for the ALU operand sequencer: data width, op and state encodings.
// No ports; imported by the sequencer top level.
// The state encoding leaves 2'd3 unused; the FSM recovers from it to LOAD_A.
package alu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_SHOW   = 2'd2
  } state_e;

  typedef struct packed {
    logic              ovf;
    logic [DATA_W-1:0] res;
  } alu_res_t;

endpackage

// File: rtl/alu_operand_sequencer_btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, stability debounce, rising-edge strobe.
// Ports: clk, rst_n (async, active-low), btn_raw (asynchronous bouncing input),
//        press (one-cycle strobe, registered one cycle after the debounced level rises).
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Only an uninterrupted run of differing samples moves the level.
      if (r_sync2 != r_level) begin
        if (r_cnt == LP_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      // Both history flops reset to 0, so reset release cannot fake a rising edge.
      r_press <= r_level & ~r_level_d;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer: captures A then B from switches on button presses, shows the 4-bit ALU result.
// Ports: clk, rst_n, sw[3:0], op[1:0], btn_enter (raw) in; disp_w..disp_z (MSB..LSB), ovf,
//        led_a/led_b/led_res out. All outputs registered; the display lags sw by one cycle.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic [1:0]        op,
  input  logic              btn_enter,
  output logic              disp_w,
  output logic              disp_x,
  output logic              disp_y,
  output logic              disp_z,
  output logic              ovf,
  output logic              led_a,
  output logic              led_b,
  output logic              led_res
);

  function automatic alu_res_t alu_calc(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input alu_op_e           opc);
    alu_res_t          r;
    logic [DATA_W-1:0] s;
    r = '0;
    s = '0;
    case (opc)
      OP_ADD: begin
        s     = a + b;
        r.res = s;
        r.ovf = (a[3] == b[3]) && (s[3] != a[3]);
      end
      OP_SUB: begin
        s     = a + ~b + 4'd1;
        r.res = s;
        r.ovf = (a[3] != b[3]) && (s[3] != a[3]);
      end
      OP_AND:  r.res = a & b;
      default: r.res = a | b;
    endcase
    return r;
  endfunction

  logic              w_press;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_disp;
  logic              r_ovf;
  logic              r_led_a;
  logic              r_led_b;
  logic              r_led_res;
  logic              w_cap_a;
  logic              w_cap_b;
  logic              w_clr_show;
  logic [DATA_W-1:0] w_b_opnd;
  logic [DATA_W-1:0] w_disp_nxt;
  alu_res_t          w_alu;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_enter),
    .press  (w_press)
  );

  // Operand B is the live switch value until it has been captured.
  assign w_b_opnd = (r_state == ST_LOAD_B) ? sw : r_b;
  assign w_alu    = alu_calc(r_a, w_b_opnd, alu_op_e'(op));

  always_comb begin
    w_state_nxt = r_state;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_clr_show  = 1'b0;
    w_disp_nxt  = sw;
    case (r_state)
      ST_LOAD_A: begin
        if (w_press) begin
          w_state_nxt = ST_LOAD_B;
          w_cap_a     = 1'b1;
        end
      end
      ST_LOAD_B: begin
        if (w_press) begin
          w_state_nxt = ST_SHOW;
          w_cap_b     = 1'b1;
        end
      end
      ST_SHOW: begin
        if (w_press) begin
          w_state_nxt = ST_LOAD_A;
          w_clr_show  = 1'b1;
        end
      end
      default: w_state_nxt = ST_LOAD_A;
    endcase
    // Display follows the state being entered so the result is visible in the first SHOW cycle.
    if (w_state_nxt == ST_SHOW) begin
      w_disp_nxt = w_cap_b ? w_alu.res : r_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD_A;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_ovf     <= 1'b0;
      r_disp    <= '0;
      r_led_a   <= 1'b1;
      r_led_b   <= 1'b0;
      r_led_res <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap_a) begin
        r_a <= sw;
      end
      if (w_cap_b) begin
        r_b   <= sw;
        r_res <= w_alu.res;
        r_ovf <= w_alu.ovf;
      end else if (w_clr_show) begin
        r_ovf <= 1'b0;
      end
      r_disp    <= w_disp_nxt;
      r_led_a   <= (w_state_nxt == ST_LOAD_A);
      r_led_b   <= (w_state_nxt == ST_LOAD_B);
      r_led_res <= (w_state_nxt == ST_SHOW);
    end
  end

  assign disp_w  = r_disp[3];
  assign disp_x  = r_disp[2];
  assign disp_y  = r_disp[1];
  assign disp_z  = r_disp[0];
  assign ovf     = r_ovf;
  assign led_a   = r_led_a;
  assign led_b   = r_led_b;
  assign led_res = r_led_res;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for the ALU operand sequencer with a short debounce window.
// Expected {ovf,result} pairs are queued when operand B is entered and popped on SHOW entry.
// Signed integer model is independent of the RTL bit-level formulation.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [1:0] op;
  logic       btn_enter;
  logic       disp_w, disp_x, disp_y, disp_z;
  logic       ovf, led_a, led_b, led_res;
  logic [3:0] disp;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .op       (op),
    .btn_enter(btn_enter),
    .disp_w   (disp_w),
    .disp_x   (disp_x),
    .disp_y   (disp_y),
    .disp_z   (disp_z),
    .ovf      (ovf),
    .led_a    (led_a),
    .led_b    (led_b),
    .led_res  (led_res)
  );

  always #5 clk = ~clk;
  assign disp = {disp_w, disp_x, disp_y, disp_z};

  // Returns {ovf, result} using signed integer arithmetic.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] o);
    int         sa;
    int         sb;
    int         r;
    logic [3:0] rv;
    logic       ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 0;
    ov = 1'b0;
    rv = 4'd0;
    case (o)
      2'd0: begin r = sa + sb; ov = (r > 7) || (r < -8); rv = r[3:0]; end
      2'd1: begin r = sa - sb; ov = (r > 7) || (r < -8); rv = r[3:0]; end
      2'd2: rv = a & b;
      default: rv = a | b;
    endcase
    return {ov, rv};
  endfunction

  task automatic press_btn(input int hi, input int lo);
    btn_enter = 1'b1;
    repeat (hi) @(negedge clk);
    btn_enter = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw = 4'b0101; op = 2'd0; btn_enter = 1'b0;
    #23;
    n_cmp++; if (disp !== 4'b0000) begin n_err++; $display("FAIL reset_disp: got %b expected 0000", disp); end
    n_cmp++; if ({led_a, led_b, led_res} !== 3'b100) begin n_err++; $display("FAIL reset_leds: got %b expected 100", {led_a, led_b, led_res}); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (disp !== 4'b0101) begin n_err++; $display("FAIL live_sw: got %b expected 0101", disp); end
    n_cmp++; if (led_a !== 1'b1) begin n_err++; $display("FAIL no_press_on_release: led_a got %b expected 1", led_a); end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
    logic       got;
    logic [4:0] exp;
    sw = a;
    press_btn(12, 12);
    n_cmp++; if (led_b !== 1'b1) begin n_err++; $display("FAIL enter_load_b: led_b got %b expected 1", led_b); end
    sw = b; op = o;
    exp_q.push_back(model(a, b, o));
    btn_enter = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (led_res === 1'b1) got = 1'b1;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL show_timeout: led_res got %b expected 1", led_res);
    end else if ({ovf, disp} !== exp) begin
      n_err++; $display("FAIL result a=%b b=%b op=%0d: got ovf,disp=%b expected %b", a, b, o, {ovf, disp}, exp);
    end
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    sw = ~b; op = ~o;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ovf, disp} !== exp) begin n_err++; $display("FAIL show_hold: got %b expected %b", {ovf, disp}, exp); end
    press_btn(12, 12);
    n_cmp++; if ({led_a, led_res, ovf} !== 3'b100) begin n_err++; $display("FAIL back_to_a: led_a,led_res,ovf got %b expected 100", {led_a, led_res, ovf}); end
  endtask

  task automatic test_arith();
    run_op(4'b0011, 4'b0100, 2'd0);  // 3+4 = 7
    run_op(4'b0111, 4'b0001, 2'd0);  // 7+1 overflows to -8
    run_op(4'b1000, 4'b0001, 2'd1);  // -8-1 overflows to 7
    run_op(4'b1110, 4'b1111, 2'd1);  // -2-(-1) = -1
  endtask

  task automatic test_logic();
    run_op(4'b1100, 4'b1010, 2'd2);
    run_op(4'b1100, 4'b1010, 2'd3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
    end
  endtask

  task automatic test_bounce();
    logic saw_show;
    sw = 4'b0010;
    press_btn(2, 10);
    for (int k = 0; k < 5; k++) press_btn(1, 1);
    repeat (12) @(negedge clk);
    n_cmp++; if (led_a !== 1'b1) begin n_err++; $display("FAIL short_pulse_ignored: led_a got %b expected 1", led_a); end
    saw_show = 1'b0;
    btn_enter = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (led_res === 1'b1) saw_show = 1'b1;
    end
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if ({led_b, saw_show} !== 2'b10) begin n_err++; $display("FAIL hold_single_press: led_b,saw_show got %b expected 10", {led_b, saw_show}); end
    sw = 4'b0001; op = 2'd0;
    press_btn(12, 12);
    n_cmp++; if ({led_res, disp} !== 5'b1_0011) begin n_err++; $display("FAIL after_hold_result: got %b expected 10011", {led_res, disp}); end
    press_btn(12, 12);
  endtask

  task automatic test_reset_mid();
    sw = 4'b0110;
    press_btn(12, 12);
    n_cmp++; if (led_b !== 1'b1) begin n_err++; $display("FAIL mid_load_b: led_b got %b expected 1", led_b); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({led_a, led_b, led_res, ovf, disp} !== 8'b100_0_0000) begin
      n_err++; $display("FAIL async_reset: got %b expected 10000000", {led_a, led_b, led_res, ovf, disp});
    end
    #8 rst_n = 1'b1;
    run_op(4'b0010, 4'b0011, 2'd0);  // a stale A of 0110 would give 1001
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
